// File: rtl/data_mem.sv
// Byte-addressable doubleword data memory for the MEM stage: one little-endian
// 64-bit read or write per clock, unaligned accesses wrap at the top of the array.
module data_mem #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    input  logic        memwrite,
    input  logic        memread
);

    localparam int NUM_LANES = 8;
    localparam int ADDR_BITS_CHECK = $clog2(DEPTH_BYTES);

    logic [7:0]           mem_q [DEPTH_BYTES];
    logic [63:0]          data_out_q;
    logic [ADDR_BITS-1:0] base;
    logic [ADDR_BITS-1:0] lane_idx [NUM_LANES];
    logic                 unused_addr_bits;
    logic                 unused_param_check;

    // High address bits alias the array, so they are deliberately dropped.
    assign base               = address[ADDR_BITS-1:0];
    assign unused_addr_bits   = ^address[63:ADDR_BITS];
    assign unused_param_check = (ADDR_BITS_CHECK == ADDR_BITS);

    // Lane index arithmetic is ADDR_BITS wide, so the carry out of the top
    // bit is lost and the access wraps modulo DEPTH_BYTES for free.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_idx[gi] = base + ADDR_BITS'(gi);
        end
    endgenerate

    // Whole-array clear on reset keeps the storage in registers rather than RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (memwrite) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                mem_q[lane_idx[k]] <= data_in[8*k +: 8];
            end
        end
    end

    // Reads sample mem_q before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= 64'd0;
        end else if (memread) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                data_out_q[8*k +: 8] <= mem_q[lane_idx[k]];
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset, little-endian write/read,
// hold, aliasing, unaligned and wrap-around access, read-before-write, reset priority.
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic [63:0] address;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        memwrite;
    logic        memread;

    int n_compared;
    int n_mismatched;

    data_mem #(
        .DEPTH_BYTES(1024),
        .ADDR_BITS  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data_in (data_in),
        .data_out(data_out),
        .memwrite(memwrite),
        .memread (memread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, got);
        end
    endtask

    // One clock with the given controls applied; outputs are sampled 1ns after the edge.
    task automatic do_cycle(input logic rst, input logic rd, input logic wr,
                            input logic [63:0] addr, input logic [63:0] din);
        reset    = rst;
        memread  = rd;
        memwrite = wr;
        address  = addr;
        data_in  = din;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        address  = 64'd0;
        data_in  = 64'd0;
        @(negedge clk);

        do_cycle(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        check_value("reset_data_out", data_out, 64'd0);

        do_cycle(1'b0, 1'b1, 1'b0, 64'h0000_0004_0000_0004, 64'd0);
        check_value("read_after_reset", data_out, 64'd0);

        do_cycle(1'b0, 1'b0, 1'b1, 64'h0000_0004_0000_0004, 64'h1234_5678_90ab_cdef);
        check_value("write_no_read_holds", data_out, 64'd0);
        check_value("mem4_byte", {56'd0, dut.mem_q[4]}, 64'h0000_0000_0000_00ef);
        check_value("mem11_byte", {56'd0, dut.mem_q[11]}, 64'h0000_0000_0000_0012);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h0000_0004_0000_0004, 64'd0);
        check_value("write_then_read", data_out, 64'h1234_5678_90ab_cdef);

        do_cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check_value("hold_cycle1", data_out, 64'h1234_5678_90ab_cdef);
        do_cycle(1'b0, 1'b0, 1'b0, 64'hxxxx_xxxx_xxxx_xxxx, 64'hxxxx_xxxx_xxxx_xxxx);
        check_value("hold_cycle2_x_inputs", data_out, 64'h1234_5678_90ab_cdef);
        check_value("x_inputs_mem4", {56'd0, dut.mem_q[4]}, 64'h0000_0000_0000_00ef);

        do_cycle(1'b0, 1'b1, 1'b0, 64'h404, 64'd0);
        check_value("alias_0x404", data_out, 64'h1234_5678_90ab_cdef);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h005, 64'd0);
        check_value("unaligned_0x005", data_out, 64'h0012_3456_7890_abcd);

        do_cycle(1'b0, 1'b0, 1'b1, 64'h3FC, 64'h1122_3344_5566_7788);
        check_value("wrap_mem3fc", {56'd0, dut.mem_q[10'h3FC]}, 64'h88);
        check_value("wrap_mem3ff", {56'd0, dut.mem_q[10'h3FF]}, 64'h55);
        check_value("wrap_mem000", {56'd0, dut.mem_q[0]}, 64'h44);
        check_value("wrap_mem003", {56'd0, dut.mem_q[3]}, 64'h11);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h3FC, 64'd0);
        check_value("wrap_read_0x3fc", data_out, 64'h1122_3344_5566_7788);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h000, 64'd0);
        check_value("read_0x000_mixed", data_out, 64'h90ab_cdef_1122_3344);

        do_cycle(1'b0, 1'b1, 1'b1, 64'h004, 64'hAAAA_AAAA_AAAA_AAAA);
        check_value("rbw_old_value", data_out, 64'h1234_5678_90ab_cdef);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h004, 64'd0);
        check_value("rbw_new_value", data_out, 64'hAAAA_AAAA_AAAA_AAAA);

        do_cycle(1'b1, 1'b1, 1'b1, 64'h004, 64'hFFFF_FFFF_FFFF_FFFF);
        check_value("reset_prio_data_out", data_out, 64'd0);
        check_value("reset_prio_mem4", {56'd0, dut.mem_q[4]}, 64'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h004, 64'd0);
        check_value("reset_prio_read_0x004", data_out, 64'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 64'h3FC, 64'd0);
        check_value("reset_prio_read_0x3fc", data_out, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
